// File: rtl/exu_br_resolve.sv
// ----------------------------------------------------------------------------
// exu_br_resolve
// Branch resolution stage that sits right after the branch comparator.
// Works out the architectural next PC of each control-transfer op and
// compares it with the fetch prediction. A mispredict produces a one-cycle
// flush and a redirect request to the IFU, which is held until the IFU
// accepts it. The stage also returns the JAL/JALR link value, reports
// misaligned-target exceptions and counts branches and mispredicts.
//
// Ports
//   clk, rst_n        clock, asynchronous active-low reset
//   in_valid/ready    op handshake; ready is low while a redirect is pending
//   in_is_br/jal/jalr op class; exactly one must be set for the op to count
//   in_br_taken       comparator result (used only for conditional branches)
//   in_pc/imm/rs1     operand context for the target computation
//   in_pred_taken/target  prediction made at fetch
//   in_tag            instruction tag, returned on link_tag
//   redir_valid/ready/pc  redirect request to the IFU (held until accepted)
//   flush             one-cycle pulse that kills younger ops
//   link_valid/data/tag   link write-back (pc+4) for JAL/JALR
//   exc_valid/tval    instruction-address-misaligned report
//   br_cnt            accepted control-transfer ops
//   mispred_cnt       redirects issued
// ----------------------------------------------------------------------------
module exu_br_resolve #(
    parameter int unsigned C_EXT = 0,
    parameter int unsigned TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_is_br,
    input  logic             in_is_jal,
    input  logic             in_is_jalr,
    input  logic             in_br_taken,
    input  logic [31:0]      in_pc,
    input  logic [31:0]      in_imm,
    input  logic [31:0]      in_rs1,
    input  logic             in_pred_taken,
    input  logic [31:0]      in_pred_target,
    input  logic [TAG_W-1:0] in_tag,
    output logic             redir_valid,
    input  logic             redir_ready,
    output logic [31:0]      redir_pc,
    output logic             flush,
    output logic             link_valid,
    output logic [31:0]      link_data,
    output logic [TAG_W-1:0] link_tag,
    output logic             exc_valid,
    output logic [31:0]      exc_tval,
    output logic [31:0]      br_cnt,
    output logic [31:0]      mispred_cnt
);

    typedef enum logic {
        S_RUN,
        S_REDIR
    } state_t;

    state_t             r_state;
    logic               r_redir_valid;
    logic [31:0]        r_redir_pc;
    logic               r_flush;
    logic               r_link_valid;
    logic [31:0]        r_link_data;
    logic [TAG_W-1:0]   r_link_tag;
    logic               r_exc_valid;
    logic [31:0]        r_exc_tval;
    logic [31:0]        r_br_cnt;
    logic [31:0]        r_mispred_cnt;

    logic               w_accept;
    logic [31:0]        w_pc_rel;
    logic [31:0]        w_jalr_sum;
    logic [31:0]        w_target;
    logic [31:0]        w_seq_pc;
    logic [31:0]        w_next_pc;
    logic               w_taken;
    logic               w_mispred;
    logic               w_misaligned;

    // Ready follows the state register so no op slips in behind a mispredict.
    assign in_ready = (r_state == S_RUN);

    assign w_accept   = in_valid & in_ready & $onehot({in_is_br, in_is_jal, in_is_jalr});

    assign w_pc_rel   = in_pc + in_imm;
    assign w_jalr_sum = in_rs1 + in_imm;
    assign w_target   = in_is_jalr ? {w_jalr_sum[31:1], 1'b0} : w_pc_rel;
    assign w_seq_pc   = in_pc + 32'd4;
    assign w_taken    = in_is_br ? in_br_taken : 1'b1;
    assign w_next_pc  = w_taken ? w_target : w_seq_pc;

    assign w_mispred    = (w_taken != in_pred_taken) |
                          (w_taken & (in_pred_target != w_target));
    assign w_misaligned = w_taken & ((C_EXT != 0) ? w_target[0] : (|w_target[1:0]));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= S_RUN;
            r_redir_valid <= 1'b0;
            r_redir_pc    <= '0;
            r_flush       <= 1'b0;
            r_link_valid  <= 1'b0;
            r_link_data   <= '0;
            r_link_tag    <= '0;
            r_exc_valid   <= 1'b0;
            r_exc_tval    <= '0;
            r_br_cnt      <= '0;
            r_mispred_cnt <= '0;
        end else begin
            r_flush      <= 1'b0;
            r_link_valid <= 1'b0;
            r_exc_valid  <= 1'b0;
            case (r_state)
                S_RUN: begin
                    if (w_accept) begin
                        r_br_cnt <= r_br_cnt + 32'd1;
                        if (w_misaligned) begin
                            // Exception wins: flush, but no link and no redirect.
                            r_exc_valid <= 1'b1;
                            r_exc_tval  <= w_target;
                            r_link_tag  <= in_tag;
                            r_flush     <= 1'b1;
                        end else begin
                            if (!in_is_br) begin
                                r_link_valid <= 1'b1;
                                r_link_data  <= w_seq_pc;
                                r_link_tag   <= in_tag;
                            end
                            if (w_mispred) begin
                                r_flush       <= 1'b1;
                                r_redir_valid <= 1'b1;
                                r_redir_pc    <= w_next_pc;
                                r_mispred_cnt <= r_mispred_cnt + 32'd1;
                                r_state       <= S_REDIR;
                            end
                        end
                    end
                end
                S_REDIR: begin
                    if (redir_ready) begin
                        r_redir_valid <= 1'b0;
                        r_state       <= S_RUN;
                    end
                end
                default: r_state <= S_RUN;
            endcase
        end
    end

    assign redir_valid = r_redir_valid;
    assign redir_pc    = r_redir_pc;
    assign flush       = r_flush;
    assign link_valid  = r_link_valid;
    assign link_data   = r_link_data;
    assign link_tag    = r_link_tag;
    assign exc_valid   = r_exc_valid;
    assign exc_tval    = r_exc_tval;
    assign br_cnt      = r_br_cnt;
    assign mispred_cnt = r_mispred_cnt;

endmodule

// File: tb/tb_exu_br_resolve.sv
// ----------------------------------------------------------------------------
// tb_exu_br_resolve
// Drives one instance with C_EXT=0 and one with C_EXT=1 from the same input
// stream. A per-instance reference model predicts every output from the
// architectural rules; directed cases reproduce the named scenarios and are
// followed by a randomized run.
// ----------------------------------------------------------------------------
module tb_exu_br_resolve;

    localparam longint unsigned MOD32 = 64'h1_0000_0000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_is_br, in_is_jal, in_is_jalr, in_br_taken;
    logic [31:0] in_pc, in_imm, in_rs1, in_pred_target;
    logic        in_pred_taken;
    logic [3:0]  in_tag;
    logic        redir_ready;

    logic        o_in_ready    [2];
    logic        o_redir_valid [2];
    logic [31:0] o_redir_pc    [2];
    logic        o_flush       [2];
    logic        o_link_valid  [2];
    logic [31:0] o_link_data   [2];
    logic [3:0]  o_link_tag    [2];
    logic        o_exc_valid   [2];
    logic [31:0] o_exc_tval    [2];
    logic [31:0] o_br_cnt      [2];
    logic [31:0] o_mispred_cnt [2];

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;

    // reference model state per instance (index = C_EXT value)
    bit          m_pend  [2];
    logic [31:0] m_rpc   [2];
    logic [31:0] m_br    [2];
    logic [31:0] m_mis   [2];
    bit          e_flush [2];
    bit          e_link  [2];
    logic [31:0] e_ldata [2];
    logic [3:0]  e_ltag  [2];
    bit          e_exc   [2];
    logic [31:0] e_tval  [2];

    always #5 clk = ~clk;

    exu_br_resolve #(.C_EXT(0), .TAG_W(4)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(o_in_ready[0]),
        .in_is_br(in_is_br), .in_is_jal(in_is_jal), .in_is_jalr(in_is_jalr),
        .in_br_taken(in_br_taken), .in_pc(in_pc), .in_imm(in_imm), .in_rs1(in_rs1),
        .in_pred_taken(in_pred_taken), .in_pred_target(in_pred_target), .in_tag(in_tag),
        .redir_valid(o_redir_valid[0]), .redir_ready(redir_ready), .redir_pc(o_redir_pc[0]),
        .flush(o_flush[0]), .link_valid(o_link_valid[0]), .link_data(o_link_data[0]),
        .link_tag(o_link_tag[0]), .exc_valid(o_exc_valid[0]), .exc_tval(o_exc_tval[0]),
        .br_cnt(o_br_cnt[0]), .mispred_cnt(o_mispred_cnt[0])
    );

    exu_br_resolve #(.C_EXT(1), .TAG_W(4)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(o_in_ready[1]),
        .in_is_br(in_is_br), .in_is_jal(in_is_jal), .in_is_jalr(in_is_jalr),
        .in_br_taken(in_br_taken), .in_pc(in_pc), .in_imm(in_imm), .in_rs1(in_rs1),
        .in_pred_taken(in_pred_taken), .in_pred_target(in_pred_target), .in_tag(in_tag),
        .redir_valid(o_redir_valid[1]), .redir_ready(redir_ready), .redir_pc(o_redir_pc[1]),
        .flush(o_flush[1]), .link_valid(o_link_valid[1]), .link_data(o_link_data[1]),
        .link_tag(o_link_tag[1]), .exc_valid(o_exc_valid[1]), .exc_tval(o_exc_tval[1]),
        .br_cnt(o_br_cnt[1]), .mispred_cnt(o_mispred_cnt[1])
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_pend[d] = 0; m_rpc[d] = '0; m_br[d] = '0; m_mis[d] = '0;
            e_flush[d] = 0; e_link[d] = 0; e_exc[d] = 0;
            e_ldata[d] = '0; e_ltag[d] = '0; e_tval[d] = '0;
        end
    endtask

    // One clock edge of architectural behaviour, using the inputs present at the edge.
    task automatic model_update();
        longint unsigned tgt, nxt;
        bit tk, mis, bad;
        int nsel;
        nsel = int'(in_is_br) + int'(in_is_jal) + int'(in_is_jalr);
        if (in_is_jalr)
            tgt = ((longint'(in_rs1) + longint'(in_imm)) % MOD32) / 2 * 2;
        else
            tgt = (longint'(in_pc) + longint'(in_imm)) % MOD32;
        tk  = in_is_br ? in_br_taken : 1'b1;
        nxt = tk ? tgt : (longint'(in_pc) + 4) % MOD32;
        mis = (tk != in_pred_taken) || (tk && (longint'(in_pred_target) != tgt));
        for (int d = 0; d < 2; d++) begin
            e_flush[d] = 0; e_link[d] = 0; e_exc[d] = 0;
            bad = tk && ((tgt % ((d == 1) ? 2 : 4)) != 0);
            if (m_pend[d]) begin
                if (redir_ready) m_pend[d] = 0;
            end else if (in_valid && nsel == 1) begin
                m_br[d] = m_br[d] + 1;
                if (bad) begin
                    e_exc[d] = 1; e_tval[d] = 32'(tgt); e_ltag[d] = in_tag; e_flush[d] = 1;
                end else begin
                    if (!in_is_br) begin
                        e_link[d] = 1; e_ltag[d] = in_tag;
                        e_ldata[d] = 32'((longint'(in_pc) + 4) % MOD32);
                    end
                    if (mis) begin
                        e_flush[d] = 1; m_pend[d] = 1; m_rpc[d] = 32'(nxt);
                        m_mis[d] = m_mis[d] + 1;
                    end
                end
            end
        end
    endtask

    task automatic check_all();
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("in_ready%0d", d), 32'(o_in_ready[d]), 32'(!m_pend[d]));
            chk($sformatf("redir_valid%0d", d), 32'(o_redir_valid[d]), 32'(m_pend[d]));
            if (m_pend[d]) chk($sformatf("redir_pc%0d", d), o_redir_pc[d], m_rpc[d]);
            chk($sformatf("flush%0d", d), 32'(o_flush[d]), 32'(e_flush[d]));
            chk($sformatf("link_valid%0d", d), 32'(o_link_valid[d]), 32'(e_link[d]));
            if (e_link[d]) begin
                chk($sformatf("link_data%0d", d), o_link_data[d], e_ldata[d]);
                chk($sformatf("link_tag%0d", d), 32'(o_link_tag[d]), 32'(e_ltag[d]));
            end
            chk($sformatf("exc_valid%0d", d), 32'(o_exc_valid[d]), 32'(e_exc[d]));
            if (e_exc[d]) begin
                chk($sformatf("exc_tval%0d", d), o_exc_tval[d], e_tval[d]);
                chk($sformatf("exc_tag%0d", d), 32'(o_link_tag[d]), 32'(e_ltag[d]));
            end
            chk($sformatf("br_cnt%0d", d), o_br_cnt[d], m_br[d]);
            chk($sformatf("mispred_cnt%0d", d), o_mispred_cnt[d], m_mis[d]);
        end
    endtask

    // Inputs are changed only right after the negedge check; the edge is modelled then checked.
    task automatic step();
        @(posedge clk);
        model_update();
        @(negedge clk);
        check_all();
    endtask

    task automatic set_op(input bit br, input bit jal, input bit jalr, input bit tk,
                          input logic [31:0] pc, input logic [31:0] imm, input logic [31:0] rs1,
                          input bit ptk, input logic [31:0] ptgt, input logic [3:0] tag);
        in_valid = 1'b1; in_is_br = br; in_is_jal = jal; in_is_jalr = jalr;
        in_br_taken = tk; in_pc = pc; in_imm = imm; in_rs1 = rs1;
        in_pred_taken = ptk; in_pred_target = ptgt; in_tag = tag;
    endtask

    task automatic random_inputs();
        logic [31:0] t;
        int sel, stp;
        bit tk;
        in_valid = ($urandom_range(0, 3) != 0);
        sel = $urandom_range(0, 9);
        {in_is_br, in_is_jal, in_is_jalr} = (sel <= 3) ? 3'b100 : (sel <= 6) ? 3'b010 :
                                            (sel <= 8) ? 3'b001 : 3'($urandom);
        in_br_taken = $urandom_range(0, 1) == 1;
        in_pc = $urandom & ~32'd3;
        if ($urandom_range(0, 7) == 0) in_pc = 32'hFFFF_FFF0 | (in_pc & 32'hC);
        stp = ($urandom_range(0, 2) == 0) ? 2 : 4;
        if ($urandom_range(0, 9) == 0) stp = 1;
        in_imm = 32'(($urandom_range(0, 1023) - 512) * stp);
        in_rs1 = $urandom;
        in_tag = 4'($urandom);
        t  = in_is_jalr ? ((in_rs1 + in_imm) & ~32'd1) : (in_pc + in_imm);
        tk = in_is_br ? in_br_taken : 1'b1;
        in_pred_taken  = ($urandom_range(0, 4) == 0) ? !tk : tk;
        in_pred_target = ($urandom_range(0, 4) == 0) ? $urandom : t;
        redir_ready = ($urandom_range(0, 2) == 0);
    endtask

    initial begin
        rst_n = 1'b0; redir_ready = 1'b0;
        set_op(0, 0, 0, 0, '0, '0, '0, 0, '0, '0);
        in_valid = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        // reset state, including held data outputs
        check_all();
        chk("rst_link_data", o_link_data[0], 32'h0);
        chk("rst_exc_tval", o_exc_tval[0], 32'h0);
        chk("rst_redir_pc", o_redir_pc[0], 32'h0);

        // BEQ correctly predicted taken
        set_op(1, 0, 0, 1, 32'h100, 32'h20, 0, 1, 32'h120, 4'h1);
        step();
        in_valid = 1'b0;
        chk("beq_flush", 32'(o_flush[0]), 32'h0);
        chk("beq_br_cnt", o_br_cnt[0], 32'd1);
        chk("beq_mis_cnt", o_mispred_cnt[0], 32'd0);

        // BNE not taken but predicted taken; redirect held for 3 cycles
        set_op(1, 0, 0, 0, 32'h200, 32'h40, 0, 1, 32'h240, 4'h2);
        step();
        chk("bne_flush", 32'(o_flush[0]), 32'h1);
        chk("bne_redir_valid", 32'(o_redir_valid[0]), 32'h1);
        chk("bne_redir_pc", o_redir_pc[0], 32'h204);
        // keep a valid op on the inputs: it must not be accepted while redirecting
        set_op(0, 1, 0, 0, 32'h500, 32'h10, 0, 0, 0, 4'h3);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("bne_hold_pc", o_redir_pc[0], 32'h204);
            chk("bne_hold_rdy", 32'(o_in_ready[0]), 32'h0);
            chk("bne_hold_flush", 32'(o_flush[0]), 32'h0);
        end
        in_valid = 1'b0;
        redir_ready = 1'b1;
        step();
        redir_ready = 1'b0;
        chk("bne_done_rv", 32'(o_redir_valid[0]), 32'h0);
        chk("bne_done_rdy", 32'(o_in_ready[0]), 32'h1);
        chk("bne_mis_cnt", o_mispred_cnt[0], 32'd1);
        chk("bne_br_cnt", o_br_cnt[0], 32'd2);

        // JALR: target 0x1006 (legal only with compressed support)
        set_op(0, 0, 1, 0, 32'h300, 32'h4, 32'h1003, 1, 32'h1000, 4'h4);
        step();
        in_valid = 1'b0;
        chk("jalr_link_valid", 32'(o_link_valid[1]), 32'h1);
        chk("jalr_link_data", o_link_data[1], 32'h304);
        chk("jalr_redir_pc", o_redir_pc[1], 32'h1006);
        chk("jalr_c0_exc", 32'(o_exc_valid[0]), 32'h1);
        redir_ready = 1'b1;
        step();
        redir_ready = 1'b0;

        // JAL to a halfword-aligned target
        set_op(0, 1, 0, 0, 32'h400, 32'h2, 0, 1, 32'h402, 4'h5);
        step();
        in_valid = 1'b0;
        chk("jal_c0_exc", 32'(o_exc_valid[0]), 32'h1);
        chk("jal_c0_tval", o_exc_tval[0], 32'h402);
        chk("jal_c0_flush", 32'(o_flush[0]), 32'h1);
        chk("jal_c0_redir", 32'(o_redir_valid[0]), 32'h0);
        chk("jal_c0_link", 32'(o_link_valid[0]), 32'h0);
        chk("jal_c1_exc", 32'(o_exc_valid[1]), 32'h0);
        step();

        // wrap-around targets; second one uses a same-cycle handshake
        set_op(0, 1, 0, 0, 32'hFFFF_FFFC, 32'h8, 0, 0, 0, 4'h6);
        step();
        in_valid = 1'b0;
        chk("wrap_jal_pc", o_redir_pc[0], 32'h4);
        redir_ready = 1'b1;
        step();
        set_op(1, 0, 0, 0, 32'hFFFF_FFFC, 32'h40, 0, 1, 32'h3C, 4'h7);
        step();
        in_valid = 1'b0;
        chk("wrap_br_pc", o_redir_pc[0], 32'h0);
        step();
        redir_ready = 1'b0;
        chk("wrap_br_done", 32'(o_redir_valid[0]), 32'h0);

        // malformed op class selections are ignored
        set_op(1, 1, 0, 1, 32'h600, 32'h8, 0, 0, 0, 4'h8);
        step();
        set_op(0, 0, 0, 1, 32'h600, 32'h8, 0, 0, 0, 4'h8);
        step();
        in_valid = 1'b0;

        // reset while a redirect is pending
        set_op(1, 0, 0, 1, 32'h700, 32'h80, 0, 0, 0, 4'h9);
        step();
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("arst_redir_valid", 32'(o_redir_valid[0]), 32'h0);
        chk("arst_flush", 32'(o_flush[0]), 32'h0);
        chk("arst_br_cnt", o_br_cnt[0], 32'h0);
        chk("arst_mis_cnt", o_mispred_cnt[0], 32'h0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        step();
        chk("arst_rdy", 32'(o_in_ready[0]), 32'h1);

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            random_inputs();
            step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
